// File: rtl/fp_pkg.sv
// Shared widths and requester-index type for the normalize/arbitrate slice.
package fp_pkg;
  localparam int unsigned SIZE_MANTIS_DEF = 26;
  localparam int unsigned SIZE_EXP_DEF    = 8;
  localparam int unsigned N_REQ           = 2;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_t;
endpackage

// File: rtl/norm_rr_arb.sv
// Two-requester round-robin arbiter; last_grant advances only on an accepted transfer.
module norm_rr_arb
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_xfer,
  output logic [N_REQ-1:0] o_grant_c
);

  req_idx_t r_last_grant;

  // A lone requester wins outright; on a tie the one not granted last time wins.
  always_comb begin
    o_grant_c = i_req;
    if (&i_req) begin
      o_grant_c = (r_last_grant == REQ1) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= REQ1;
    end else if (i_xfer) begin
      r_last_grant <= o_grant_c[1] ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/norm_arb.sv
// Two requesters share one combinational mantissa normalizer feeding a 1-deep result register.
// Optional NORM_ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module norm_arb
  import fp_pkg::*;
#(
  parameter int unsigned SIZE_MANTIS = SIZE_MANTIS_DEF,
  parameter int unsigned SIZE_EXP    = SIZE_EXP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic                   req1_valid,
  output logic                   req0_ready,
  output logic                   req1_ready,
  input  logic [SIZE_EXP-1:0]    req0_exp,
  input  logic [SIZE_EXP-1:0]    req1_exp,
  input  logic [SIZE_MANTIS-1:0] req0_mantis,
  input  logic [SIZE_MANTIS-1:0] req1_mantis,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIZE_EXP-1:0]    out_exp,
  output logic [SIZE_MANTIS-1:0] out_mantis,
  output logic                   out_src
`ifdef NORM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int unsigned SHIFT_W = $clog2(SIZE_MANTIS + 1);

  logic [N_REQ-1:0]       w_req;
  logic [N_REQ-1:0]       w_grant;
  logic                   w_can_accept;
  logic                   w_xfer;
  logic                   w_sel1;
  logic [SIZE_EXP-1:0]    w_in_exp;
  logic [SIZE_MANTIS-1:0] w_in_mantis;
  logic [SHIFT_W-1:0]     w_shift;
  logic [SIZE_EXP-1:0]    w_norm_exp;
  logic [SIZE_MANTIS-1:0] w_norm_mantis;

  assign w_req = {req1_valid, req0_valid};

  norm_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_xfer    (w_xfer),
    .o_grant_c (w_grant)
  );

  // Register drained this cycle may be refilled this cycle.
  assign w_can_accept = !out_valid || out_ready;
  assign req0_ready   = w_grant[0] && w_can_accept && !rst;
  assign req1_ready   = w_grant[1] && w_can_accept && !rst;
  assign w_xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign w_sel1      = w_grant[1];
  assign w_in_exp    = w_sel1 ? req1_exp : req0_exp;
  assign w_in_mantis = w_sel1 ? req1_mantis : req0_mantis;

  // Leading-zero count; highest set bit wins, zero mantissa leaves shift at 0.
  always_comb begin
    w_shift = '0;
    for (int i = 0; i < int'(SIZE_MANTIS); i++) begin
      if (w_in_mantis[i]) begin
        w_shift = SHIFT_W'(int'(SIZE_MANTIS) - 1 - i);
      end
    end
  end

  // Exponent floors at zero: a small exponent limits how far the mantissa moves.
  always_comb begin
    w_norm_exp    = '0;
    w_norm_mantis = w_in_mantis << w_in_exp;
    if (32'(w_in_exp) >= 32'(w_shift)) begin
      w_norm_exp    = w_in_exp - SIZE_EXP'(w_shift);
      w_norm_mantis = w_in_mantis << w_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_exp    <= '0;
      out_mantis <= '0;
      out_src    <= 1'b0;
    end else if (w_xfer) begin
      out_valid  <= 1'b1;
      out_exp    <= w_norm_exp;
      out_mantis <= w_norm_mantis;
      out_src    <= w_sel1;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef NORM_ARB_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_norm_arb.sv
// Self-checking bench for norm_arb: directed table, scoreboard model, stall and reset sequences.
module tb_norm_arb;
  localparam int unsigned SM = 26;
  localparam int unsigned SE = 8;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [SE-1:0] req0_exp, req1_exp;
  logic [SM-1:0] req0_mantis, req1_mantis;
  logic          out_valid, out_ready;
  logic [SE-1:0] out_exp;
  logic [SM-1:0] out_mantis;
  logic          out_src;
`ifdef NORM_ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  norm_arb #(.SIZE_MANTIS(SM), .SIZE_EXP(SE)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .req0_exp    (req0_exp),
    .req1_exp    (req1_exp),
    .req0_mantis (req0_mantis),
    .req1_mantis (req1_mantis),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_exp     (out_exp),
    .out_mantis  (out_mantis),
    .out_src     (out_src)
`ifdef NORM_ARB_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference normalizer: step the mantissa left one bit at a time.
  function automatic logic [SE+SM-1:0] tb_norm(input logic [SE-1:0] e, input logic [SM-1:0] m);
    logic [SE-1:0] ee;
    logic [SM-1:0] mm;
    ee = e;
    mm = m;
    while (mm != '0 && !mm[SM-1] && ee != '0) begin
      mm = mm << 1;
      ee = ee - 8'd1;
    end
    return {ee, mm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: model grant/ready/out_valid and queue expected results at transfer time.
  logic [SE+SM:0] sb_q[$];
  logic           m_ov   = 1'b0;
  logic           m_last = 1'b1;

  always @(negedge clk) begin
    logic can, g0, g1, e0, e1;
    logic [SE+SM:0] front;
    if (rst) begin
      m_ov   = 1'b0;
      m_last = 1'b1;
      sb_q.delete();
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      can = !m_ov || out_ready;
      if (req0_valid && req1_valid) begin
        g0 = m_last;
        g1 = !m_last;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
      e0 = g0 && can;
      e1 = g1 && can;
      chk("sb_rdy0", req0_ready, e0);
      chk("sb_rdy1", req1_ready, e1);
      chk("sb_out_valid", out_valid, m_ov);
      if (m_ov) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty act=0 exp=1");
        end else begin
          front = sb_q[0];
          chk("sb_src", out_src, front[SE+SM]);
          chk("sb_exp", out_exp, front[SE+SM-1:SM]);
          chk("sb_mantis", out_mantis, front[SM-1:0]);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      if (e0 || e1) begin
        sb_q.push_back(e1 ? {1'b1, tb_norm(req1_exp, req1_mantis)}
                          : {1'b0, tb_norm(req0_exp, req0_mantis)});
        m_last = e1;
        m_ov   = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  typedef struct {
    logic          v0, v1;
    logic [SE-1:0] e0, e1;
    logic [SM-1:0] m0, m1;
    logic [SE-1:0] xe;
    logic [SM-1:0] xm;
    logic          xs;
  } vec_t;

  vec_t tbl[7];

  task automatic pulse_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'd10,  8'd0, 26'h0400000, 26'h0,       8'd7,  26'h2000000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'd0,   8'd2, 26'h0,       26'h0000100, 8'd0,  26'h0000400, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 8'h55,  8'd0, 26'h0,       26'h0,       8'h55, 26'h0,       1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'd0,   8'd0, 26'h0,       26'h0000001, 8'd0,  26'h0000001, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 8'd30,  8'd0, 26'h0000001, 26'h0,       8'd5,  26'h2000000, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'd0,   8'd3, 26'h0,       26'h3FFFFFF, 8'd3,  26'h3FFFFFF, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 8'd25,  8'd0, 26'h0000001, 26'h0,       8'd0,  26'h2000000, 1'b0};

    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_exp = '0; req1_exp = '0;
    req0_mantis = '0; req1_mantis = '0;
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_exp", out_exp, 0);
    chk("reset_out_mantis", out_mantis, 0);
    chk("reset_out_src", out_src, 0);
    chk("reset_rdy0", req0_ready, 0);
    chk("reset_rdy1", req1_ready, 0);
`ifdef NORM_ARB_STALL_CNT_EN
    chk("reset_stall_cnt", stall_cnt, 0);
`endif
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 7; i++) begin
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      req0_exp = tbl[i].e0;   req1_exp = tbl[i].e1;
      req0_mantis = tbl[i].m0; req1_mantis = tbl[i].m1;
      cyc();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_exp", i), out_exp, tbl[i].xe);
      chk($sformatf("tbl%0d_mantis", i), out_mantis, tbl[i].xm);
      chk($sformatf("tbl%0d_src", i), out_src, tbl[i].xs);
      cyc();
    end

    // Both valid with out_ready high: grants alternate starting at requester 0.
    pulse_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req0_exp = SE'($urandom_range(0, 255)); req0_mantis = SM'($urandom);
      req1_exp = SE'($urandom_range(0, 255)); req1_mantis = SM'($urandom);
      cyc();
      chk($sformatf("alt%0d_valid", k), out_valid, 1);
      chk($sformatf("alt%0d_src", k), out_src, k % 2);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    cyc();

    // Stall: result held for five cycles, then released with a same-cycle refill.
    pulse_reset();
    req0_valid = 1'b1; req0_exp = 8'd10; req0_mantis = 26'h0400000;
    cyc();
    out_ready = 1'b0;
    req1_valid = 1'b1; req1_exp = 8'd4; req1_mantis = 26'h0800000;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_valid", out_valid, 1);
      chk("stall_exp", out_exp, 8'd7);
      chk("stall_mantis", out_mantis, 26'h2000000);
      chk("stall_rdy0", req0_ready, 0);
      chk("stall_rdy1", req1_ready, 0);
    end
`ifdef NORM_ARB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 5);
`endif
    out_ready = 1'b1;
    #1;
    chk("release_rdy1", req1_ready, 1);
    chk("release_rdy0", req0_ready, 0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("release_src", out_src, 1);
    chk("release_exp", out_exp, 8'd2);
    chk("release_mantis", out_mantis, 26'h2000000);
    cyc();

    // Reset while a result is held: dropped at once, tie goes to requester 0 afterwards.
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_exp = 8'h55; req0_mantis = 26'h0;
    cyc();
    req0_valid = 1'b0;
    chk("zero_exp", out_exp, 8'h55);
    chk("zero_mantis", out_mantis, 0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_rdy0", req0_ready, 0);
    cyc();
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("post_rst_valid", out_valid, 0);
    req0_valid = 1'b1; req0_exp = 8'd1; req0_mantis = 26'h1000000;
    req1_valid = 1'b1; req1_exp = 8'd1; req1_mantis = 26'h1000000;
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("post_rst_src", out_src, 0);
    chk("post_rst_exp", out_exp, 8'd0);
    cyc();
    cyc();
    chk("drain_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/norm_arb.md
NORM_ARB -- requirements
Module: norm_arb

Interface
- REQ-001 SHALL have parameter SIZE_MANTIS, default 26, mantissa width in bits.
- REQ-002 SHALL have parameter SIZE_EXP, default 8, exponent width in bits.
- REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
- REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
- REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each, requester n offers an operand.
- REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 each, requester n's operand is accepted this cycle.
- REQ-007 SHALL have ports req0_exp/req1_exp, input, SIZE_EXP each, unnormalized exponent.
- REQ-008 SHALL have ports req0_mantis/req1_mantis, input, SIZE_MANTIS each, unnormalized mantissa.
- REQ-009 SHALL have port out_valid, output, 1, result register holds a valid result.
- REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
- REQ-011 SHALL have ports out_exp (SIZE_EXP), out_mantis (SIZE_MANTIS) and out_src (1), all outputs, carrying the normalized result and the index of the requester that produced it.

Function
- REQ-012 SHALL share one combinational normalize unit between both requesters; exactly one operand is normalized per cycle.
- REQ-013 SHALL define transfer: input n transfers when reqn_valid && reqn_ready; output transfers when out_valid && out_ready.
- REQ-014 SHALL set can_accept = !out_valid || out_ready, so a full register drained in a cycle can be refilled in the same cycle.
- REQ-015 SHALL assert at most one of req0_ready/req1_ready, and only when can_accept is true; ready is driven combinationally from valid, can_accept and the pointer.
- REQ-016 SHALL arbitrate round-robin: if one requester is valid it is granted; if both are valid, the requester other than last_grant is granted.
- REQ-017 SHALL update last_grant only on an input transfer.
- REQ-018 SHALL normalize: shift = count of leading zeros of the mantissa (0 if MSB set or mantissa zero); if exp >= shift, mantissa << shift and exp - shift; else mantissa << exp and exp 0.
- REQ-019 SHALL register the result with latency exactly 1 cycle: out_valid rises the cycle after an input transfer.
- REQ-020 SHALL hold out_exp/out_mantis/out_src stable while out_valid && !out_ready.
- REQ-021 SHALL clear out_valid after an output transfer with no input transfer in the same cycle.
- REQ-022 SHALL keep sustained throughput of one result per cycle when out_ready is held high.
- REQ-023 SHALL not assert any reqn_ready in the reset cycle or while rst is high.

Reset
- REQ-024 SHALL on rst: out_valid=0, out_exp=0, out_mantis=0, out_src=0, last_grant=1 (requester 0 wins the first tie).
- REQ-025 SHALL discard an in-flight result when reset asserts mid-operation; no output transfer follows reset release until a new input transfer.

Configuration
- REQ-026 SHALL when NORM_ARB_STALL_CNT_EN is defined, add output stall_cnt [15:0]: counts cycles with out_valid && !out_ready, saturates at 0xFFFF, reset to 0.
- REQ-027 SHALL when NORM_ARB_STALL_CNT_EN is undefined, omit the stall_cnt port and its counter; all other behaviour identical.

Structure
- REQ-028 SHALL place SIZE_MANTIS/SIZE_EXP defaults and the requester-index type in shared package fp_pkg.
- REQ-029 SHALL implement arbitration in one sub-module norm_rr_arb (two requests, grant vector, last_grant register); normalization stays combinational inside norm_arb.

Verification
- REQ-030 SHALL cover: req0 exp=10, mantis=0x0400000, out_ready=1 -> next cycle out_exp=7, out_mantis=0x2000000, out_src=0.
- REQ-031 SHALL cover: req1 exp=2, mantis=0x0000100 -> out_exp=0, out_mantis=0x0000400, out_src=1.
- REQ-032 SHALL cover: both valid continuously, out_ready=1 -> grants alternate 0,1,0,1 starting with 0; one result per cycle.
- REQ-033 SHALL cover: out_ready=0 for 5 cycles with result held -> both reqn_ready=0, output stable, stall_cnt=5 when macro defined; out_ready=1 then accepts the next operand in the same cycle.
- REQ-034 SHALL cover: mantis=0, exp=0x55 -> out_exp=0x55, out_mantis=0; rst pulsed while out_valid=1 -> out_valid=0 immediately, last_grant=1.
